// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
package mux2_rr_arbiter_pkg;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;

  // Default hold limit: consecutive grant cycles while the other side waits
  localparam int DEF_MAX_HOLD = 4;

  // Hold counter width; a single bit even when MAX_HOLD is 1
  function automatic int hold_cnt_w(input int max_hold);
    return (max_hold > 1) ? $clog2(max_hold) : 1;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_hold_counter.sv
// Grant hold counter: clears on grant entry, counts while the grant is kept,
// and wraps to zero after terminal count so it can never overflow.
module mux2_hold_counter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = hold_cnt_w(MAX_HOLD);
  localparam logic [CW-1:0] TC_VAL = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == TC_VAL);

  // Next count: clear wins, terminal count restarts at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = tc ? '0 : cnt_q + CW'(1);
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux2_rr_arbiter_mux2_cell.sv
// Gate-level 2:1 mux bit cell: y = s ? a1 : a0.
module mux2_cell (
  input  logic a0,
  input  logic a1,
  input  logic s,
  output logic y
);

  logic s_n;
  logic t0;
  logic t1;

  not u_inv (s_n, s);
  and u_and0 (t0, a0, s_n);
  and u_and1 (t1, a1, s);
  or  u_or   (y, t0, t1);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving the select of a shared 2:1 mux.
// Grants, select and VALID are registered; Y is purely combinational.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int W        = 4,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         REQ0,
  input  logic         REQ1,
  input  logic [W-1:0] A0,
  input  logic [W-1:0] A1,
  output logic         GNT0,
  output logic         GNT1,
  output logic         S,
  output logic [W-1:0] Y,
  output logic         VALID
);

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   s_q, s_d;
  logic   gnt0_q, gnt0_d;
  logic   gnt1_q, gnt1_d;
  logic   valid_q, valid_d;
  logic   cnt_clr;
  logic   cnt_en;
  logic   hold_tc;

  mux2_hold_counter #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold (
    .clk  (CLK),
    .rst_n(RST_N),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (hold_tc)
  );

  // Next-state, LAST pointer, select and grant decode
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    s_d     = s_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ0 && REQ1)
          state_d = last_q ? ST_G0 : ST_G1;
        else if (REQ0)
          state_d = ST_G0;
        else if (REQ1)
          state_d = ST_G1;
      end
      ST_G0: begin
        if (REQ0) begin
          if (hold_tc && REQ1)
            state_d = ST_G1;
          else
            cnt_en = 1'b1;
        end else if (REQ1) begin
          state_d = ST_G1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_G1: begin
        if (REQ1) begin
          if (hold_tc && REQ0)
            state_d = ST_G0;
          else
            cnt_en = 1'b1;
        end else if (REQ0) begin
          state_d = ST_G0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any state change restarts the hold count (grant entry or drop to idle)
    if (state_d != state_q) begin
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
    end

    // Select follows the owner; in idle it holds so Y does not glitch
    if (state_d == ST_G0) begin
      last_d = 1'b0;
      s_d    = 1'b0;
    end else if (state_d == ST_G1) begin
      last_d = 1'b1;
      s_d    = 1'b1;
    end

    gnt0_d  = (state_d == ST_G0);
    gnt1_d  = (state_d == ST_G1);
    valid_d = gnt0_d | gnt1_d;
  end

  // Arbiter state and registered outputs; LAST=1 so requester 0 wins first tie
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      s_q     <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      s_q     <= s_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      valid_q <= valid_d;
    end
  end

  assign GNT0  = gnt0_q;
  assign GNT1  = gnt1_q;
  assign S     = s_q;
  assign VALID = valid_q;

  // Unregistered datapath: one mux cell per bit, all sharing S
  for (genvar i = 0; i < W; i++) begin : g_mux
    mux2_cell u_cell (
      .a0(A0[i]),
      .a1(A1[i]),
      .s (s_q),
      .y (Y[i])
    );
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: a MAX_HOLD=4 and a MAX_HOLD=1 instance share
// stimulus and are compared each cycle against a behavioural model.
module tb_mux2_rr_arbiter;

  localparam int W = 4;

  logic         CLK;
  logic         RST_N;
  logic         REQ0;
  logic         REQ1;
  logic [W-1:0] A0;
  logic [W-1:0] A1;

  logic         g0_a, g1_a, s_a, v_a;
  logic [W-1:0] y_a;
  logic         g0_b, g1_b, s_b, v_b;
  logic [W-1:0] y_b;

  int vectors;
  int miscompares;

  // model state per instance: owner (-1 none), cycles held, last winner, select
  int   m_own  [2];
  int   m_run  [2];
  int   m_last [2];
  logic m_s    [2];

  mux2_rr_arbiter #(.W(W), .MAX_HOLD(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1), .A0(A0), .A1(A1),
    .GNT0(g0_a), .GNT1(g1_a), .S(s_a), .Y(y_a), .VALID(v_a)
  );

  mux2_rr_arbiter #(.W(W), .MAX_HOLD(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1), .A0(A0), .A1(A1),
    .GNT0(g0_b), .GNT1(g1_b), .S(s_b), .Y(y_b), .VALID(v_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int hold_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = -1;
      m_run[k]  = 0;
      m_last[k] = 1;
      m_s[k]    = 1'b0;
    end
  endtask

  // One rising edge of the reference rules for instance k
  task automatic model_edge(input int k);
    logic r [2];
    int   o;
    r[0] = REQ0;
    r[1] = REQ1;
    o = m_own[k];
    if (o < 0) begin
      if (r[0] && r[1]) m_own[k] = 1 - m_last[k];
      else if (r[0])    m_own[k] = 0;
      else if (r[1])    m_own[k] = 1;
      if (m_own[k] >= 0) begin
        m_run[k]  = 1;
        m_last[k] = m_own[k];
      end
    end else if (!r[o]) begin
      if (r[1-o]) begin
        m_own[k]  = 1 - o;
        m_run[k]  = 1;
        m_last[k] = m_own[k];
      end else begin
        m_own[k] = -1;
      end
    end else if (m_run[k] >= hold_of(k)) begin
      if (r[1-o]) begin
        m_own[k]  = 1 - o;
        m_last[k] = m_own[k];
      end
      m_run[k] = 1;
    end else begin
      m_run[k]++;
    end
    if (m_own[k] >= 0) m_s[k] = (m_own[k] == 1);
  endtask

  task automatic check_outs(input string tag);
    logic [W-1:0] ye0, ye1;
    ye0 = m_s[0] ? A1 : A0;
    ye1 = m_s[1] ? A1 : A0;
    chk({tag, " gnt0 h4"},  32'(g0_a), 32'(m_own[0] == 0));
    chk({tag, " gnt1 h4"},  32'(g1_a), 32'(m_own[0] == 1));
    chk({tag, " valid h4"}, 32'(v_a),  32'(m_own[0] >= 0));
    chk({tag, " s h4"},     32'(s_a),  32'(m_s[0]));
    chk({tag, " y h4"},     32'(y_a),  32'(ye0));
    chk({tag, " gnt0 h1"},  32'(g0_b), 32'(m_own[1] == 0));
    chk({tag, " gnt1 h1"},  32'(g1_b), 32'(m_own[1] == 1));
    chk({tag, " valid h1"}, 32'(v_b),  32'(m_own[1] >= 0));
    chk({tag, " s h1"},     32'(s_b),  32'(m_s[1]));
    chk({tag, " y h1"},     32'(y_b),  32'(ye1));
    chk({tag, " excl h4"},  32'(g0_a & g1_a), 32'(0));
    chk({tag, " excl h1"},  32'(g0_b & g1_b), 32'(0));
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge(0);
    model_edge(1);
    #1;
    check_outs(tag);
  endtask

  // Asynchronous reset pulse placed between edges, released before next edge
  task automatic reset_pulse(input string tag);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_outs(tag);
    chk({tag, " async gnt drop"}, 32'({g0_a, g1_a, v_a}), 32'(0));
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST_N = 1'b1;
    REQ0  = 1'b1;
    REQ1  = 1'b1;
    A0    = 4'h3;
    A1    = 4'hA;
    model_reset();

    // Reset held with both requesting
    #1 RST_N = 1'b0;
    #1 check_outs("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    step("tie");
    chk("first tie to req0", 32'(g0_a), 32'(1));

    // Single requester 1, held 10 cycles
    reset_pulse("rst2");
    REQ0 = 1'b0;
    REQ1 = 1'b1;
    step("single");
    chk("single y", 32'(y_a), 32'(4'hA));
    for (int i = 0; i < 10; i++) step("single hold");
    chk("single still granted", 32'(g1_a), 32'(1));

    // Fairness with both requesting continuously
    REQ0 = 1'b1;
    for (int i = 0; i < 17; i++) step("fair");

    // Handover: owner drops while other waits, then all drop
    reset_pulse("rst3");
    REQ0 = 1'b1;
    REQ1 = 1'b0;
    step("ho g0");
    REQ0 = 1'b0;
    REQ1 = 1'b1;
    step("ho switch");
    chk("ho no bubble", 32'(v_a), 32'(1));
    REQ1 = 1'b0;
    step("ho idle");
    chk("ho s held", 32'(s_a), 32'(1));
    step("ho idle2");

    // Mid-grant reset from G1 at count 2
    REQ1 = 1'b1;
    for (int i = 0; i < 3; i++) step("mid g1");
    REQ0 = 1'b1;
    reset_pulse("mid rst");
    step("mid restart");
    chk("mid restart gnt0", 32'(g0_a), 32'(1));

    // Withdrawn-before-grant: pulse between edges never sampled
    reset_pulse("rst4");
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    step("wd idle");
    #2 REQ1 = 1'b1;
    #2 REQ1 = 1'b0;
    step("wd none");

    // Randomized traffic with sticky requests and rare resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(3) == 0) REQ0 = ~REQ0;
      if ($urandom_range(3) == 0) REQ1 = ~REQ1;
      A0 = W'($urandom);
      A1 = W'($urandom);
      if ($urandom_range(63) == 0) reset_pulse("rand rst");
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
